// File: rtl/vgm_pkg.sv
`default_nettype none
// ============================================================================
// Module  : vgm_pkg
// Brief   : VGM opcodes, wait constants and sequencer state encoding.
// Revision: 1.0 - initial release
// ============================================================================
package vgm_pkg;

    localparam logic [7:0] C_OP_GG_STEREO = 8'h4F;
    localparam logic [7:0] C_OP_PSG_WR    = 8'h50;
    localparam logic [7:0] C_OP_WAIT_N    = 8'h61;
    localparam logic [7:0] C_OP_WAIT_735  = 8'h62;
    localparam logic [7:0] C_OP_WAIT_882  = 8'h63;
    localparam logic [7:0] C_OP_END       = 8'h66;
    localparam logic [7:0] C_OP_WAIT_SHORT = 8'h70;

    localparam logic [15:0] C_WAIT_NTSC = 16'd735;
    localparam logic [15:0] C_WAIT_PAL  = 16'd882;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_FETCH_OP = 4'd1,
        ST_FETCH_D0 = 4'd2,
        ST_FETCH_D1 = 4'd3,
        ST_WR_HI    = 4'd4,
        ST_WR_LO    = 4'd5,
        ST_WAIT     = 4'd6,
        ST_DONE     = 4'd7,
        ST_ERR      = 4'd8
    } state_e;

endpackage
`default_nettype wire

// File: rtl/vgm_wait_timer.sv
`default_nettype none
// ============================================================================
// Module  : vgm_wait_timer
// Brief   : 16-bit sample-tick down-counter with load, tick enable and zero flag.
// Revision: 1.0 - initial release
// ============================================================================
module vgm_wait_timer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic [15:0] load_val_i,
    input  logic        tick_i,
    output logic        zero_o,
    output logic        expire_o
);

    logic [15:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (tick_i && (cnt_q != 16'd0)) begin
            cnt_q <= cnt_q - 16'd1;
        end
    end

    assign zero_o   = (cnt_q == 16'd0);
    // Flags the tick that empties the counter so the FSM can leave WAIT on that same edge
    assign expire_o = tick_i && (cnt_q == 16'd1);

endmodule
`default_nettype wire

// File: rtl/vgm_psg_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : vgm_psg_sequencer
// Brief   : Plays a VGM byte stream into the SN76489 write port (PSG writes, waits).
//           Optional: VGM_PSG_SEQ_GG_STEREO_EN accepts and discards opcode 0x4F.
// Revision: 1.0 - initial release
// ============================================================================
module vgm_psg_sequencer
    import vgm_pkg::*;
#(
    parameter int unsigned WR_PULSE = 2,
    parameter int unsigned WR_GAP   = 2
) (
    input  logic       in_clk,
    input  logic       in_rst_n,
    input  logic       in_start,
    input  logic [7:0] in_byte,
    input  logic       in_byte_valid,
    output logic       out_byte_ready,
    input  logic       in_tick,
    output logic [7:0] out_val,
    output logic       out_wr,
    output logic       out_busy,
    output logic       out_done,
    output logic       out_err,
    output logic [7:0] out_err_op
);

    localparam logic [7:0] C_PULSE_LAST = 8'(WR_PULSE - 1);
    localparam logic [7:0] C_GAP_LAST   = 8'(WR_GAP - 1);

    state_e      state_q, state_d;
    logic [7:0]  pcnt_q, pcnt_d;
    logic [7:0]  op_q, op_d;
    logic [7:0]  d0_q, d0_d;
    logic [7:0]  val_q, val_d;
    logic [7:0]  err_op_q, err_op_d;
    logic        wr_q, ready_q, busy_q, done_q, err_q;

    logic        w_xfer;
    logic        w_load;
    logic [15:0] w_load_val;
    logic        w_tick_en;
    logic        w_zero;
    logic        w_expire;

    assign w_xfer    = in_byte_valid && ready_q;
    assign w_tick_en = (state_q == ST_WAIT) && in_tick;

    vgm_wait_timer u_timer (
        .clk        (in_clk),
        .rst_n      (in_rst_n),
        .load_i     (w_load),
        .load_val_i (w_load_val),
        .tick_i     (w_tick_en),
        .zero_o     (w_zero),
        .expire_o   (w_expire)
    );

    always_comb begin
        state_d    = state_q;
        pcnt_d     = pcnt_q;
        op_d       = op_q;
        d0_d       = d0_q;
        val_d      = val_q;
        err_op_d   = err_op_q;
        w_load     = 1'b0;
        w_load_val = 16'd0;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (in_start) begin
                    state_d  = ST_FETCH_OP;
                    err_op_d = 8'h00;
                end
            end
            ST_FETCH_OP: begin
                if (w_xfer) begin
                    op_d = in_byte;
                    case (in_byte)
                        C_OP_PSG_WR, C_OP_WAIT_N: state_d = ST_FETCH_D0;
`ifdef VGM_PSG_SEQ_GG_STEREO_EN
                        C_OP_GG_STEREO:           state_d = ST_FETCH_D0;
`endif
                        C_OP_WAIT_735: begin
                            w_load     = 1'b1;
                            w_load_val = C_WAIT_NTSC;
                            state_d    = ST_WAIT;
                        end
                        C_OP_WAIT_882: begin
                            w_load     = 1'b1;
                            w_load_val = C_WAIT_PAL;
                            state_d    = ST_WAIT;
                        end
                        C_OP_END: state_d = ST_DONE;
                        default: begin
                            if (in_byte[7:4] == C_OP_WAIT_SHORT[7:4]) begin
                                w_load     = 1'b1;
                                w_load_val = {12'd0, in_byte[3:0]} + 16'd1;
                                state_d    = ST_WAIT;
                            end else begin
                                err_op_d = in_byte;
                                state_d  = ST_ERR;
                            end
                        end
                    endcase
                end
            end
            ST_FETCH_D0: begin
                if (w_xfer) begin
                    if (op_q == C_OP_PSG_WR) begin
                        val_d   = in_byte;
                        pcnt_d  = 8'd0;
                        state_d = ST_WR_HI;
                    end else if (op_q == C_OP_WAIT_N) begin
                        d0_d    = in_byte;
                        state_d = ST_FETCH_D1;
                    end else begin
                        // Game Gear stereo byte: consumed, no PSG effect
                        state_d = ST_FETCH_OP;
                    end
                end
            end
            ST_FETCH_D1: begin
                if (w_xfer) begin
                    if ({in_byte, d0_q} == 16'd0) begin
                        state_d = ST_FETCH_OP;
                    end else begin
                        w_load     = 1'b1;
                        w_load_val = {in_byte, d0_q};
                        state_d    = ST_WAIT;
                    end
                end
            end
            ST_WR_HI: begin
                if (pcnt_q == C_PULSE_LAST) begin
                    pcnt_d  = 8'd0;
                    state_d = ST_WR_LO;
                end else begin
                    pcnt_d = pcnt_q + 8'd1;
                end
            end
            ST_WR_LO: begin
                if (pcnt_q == C_GAP_LAST) begin
                    pcnt_d  = 8'd0;
                    state_d = ST_FETCH_OP;
                end else begin
                    pcnt_d = pcnt_q + 8'd1;
                end
            end
            ST_WAIT: begin
                if (w_expire || w_zero) begin
                    state_d = ST_FETCH_OP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q  <= ST_IDLE;
            pcnt_q   <= 8'd0;
            op_q     <= 8'd0;
            d0_q     <= 8'd0;
            val_q    <= 8'd0;
            err_op_q <= 8'd0;
            wr_q     <= 1'b0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pcnt_q   <= pcnt_d;
            op_q     <= op_d;
            d0_q     <= d0_d;
            val_q    <= val_d;
            err_op_q <= err_op_d;
            wr_q     <= (state_d == ST_WR_HI);
            ready_q  <= (state_d == ST_FETCH_OP) || (state_d == ST_FETCH_D0) ||
                        (state_d == ST_FETCH_D1);
            busy_q   <= !((state_d == ST_IDLE) || (state_d == ST_DONE) ||
                          (state_d == ST_ERR));
            done_q   <= (state_d == ST_DONE);
            err_q    <= (state_d == ST_ERR);
        end
    end

    assign out_byte_ready = ready_q;
    assign out_val        = val_q;
    assign out_wr         = wr_q;
    assign out_busy       = busy_q;
    assign out_done       = done_q;
    assign out_err        = err_q;
    assign out_err_op     = err_op_q;

endmodule
`default_nettype wire
